// File: rtl/cnn_pkg.sv
// ----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the CNN pooling datapath.
//   DATA_W    : sample width (two's complement)
//   MAX_COLS  : widest supported input row; the line buffer holds MAX_COLS/2
//   DIM_W     : width of the row/column count inputs and counters
//   ACC_W     : partial-sum width, wide enough for a 4-sample sum
//   pool_state_t : pooling control states
//   sample_t / acc_t : signed sample and partial-sum types
// ----------------------------------------------------------------------------
package cnn_pkg;

    localparam int DATA_W   = 16;
    localparam int MAX_COLS = 28;
    localparam int DIM_W    = 6;
    localparam int ACC_W    = DATA_W + 2;
    localparam int LB_DEPTH = MAX_COLS / 2;
    localparam int LB_AW    = $clog2(LB_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        EVEN_ROW,
        ODD_ROW,
        DRAIN
    } pool_state_t;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/pool_line_buf.sv
// ----------------------------------------------------------------------------
// pool_line_buf
// Half-row line buffer: LB_DEPTH x ACC_W register array holding the
// horizontal pair results of the last even input row.
//   clk, reset : clock and synchronous active-high reset
//   wr_en_i    : write wr_data_i to entry addr_i on the rising edge
//   addr_i     : shared read/write address (pair index = column / 2)
//   wr_data_i  : pair result to store
//   rd_data_o  : combinational read of entry addr_i
// ----------------------------------------------------------------------------
module pool_line_buf
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [LB_AW-1:0] addr_i,
    input  acc_t             wr_data_i,
    output acc_t             rd_data_o
);

    acc_t mem_q [LB_DEPTH];

    // NOTE: this array is small and must come out of reset cleared, so it is
    // built from resettable flops; a RAM macro would not be reset here.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LB_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/pool_2x2_stream.sv
// ----------------------------------------------------------------------------
// pool_2x2_stream
// Streaming 2x2 stride-2 pooling of a raster-ordered feature map. Even-row
// pair results are parked in a half-row line buffer and combined with the
// matching odd-row pair; trailing odd column/row samples are consumed and
// dropped. One output register sits on the output handshake.
//
// Build option: define POOL_MAX_EN for max pooling; by default the window is
// averaged (4-sample sum, arithmetic shift right by 2 = floor division).
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, cols, rows   : start pulse and map dimensions (latched in IDLE)
//   in_valid/in_ready   : input handshake, in_data = convolution result
//   out_valid/out_ready : output handshake, out_data = pooled result
//   busy                : map in progress
//   finish              : one-cycle pulse after the last output is taken
// ----------------------------------------------------------------------------
module pool_2x2_stream
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  cols,
    input  logic [DIM_W-1:0]  rows,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              finish
);

    pool_state_t      state_q, state_d;
    logic [DIM_W-1:0] cols_q, rows_q, col_q, row_q;
    acc_t             hold_q;
    logic             out_valid_q;
    sample_t          out_data_q;
    logic             finish_q;

    function automatic acc_t combine(input acc_t a, input acc_t b);
`ifdef POOL_MAX_EN
        return (a > b) ? a : b;
`else
        return a + b;
`endif
    endfunction

    function automatic sample_t finalize(input acc_t w);
`ifdef POOL_MAX_EN
        return w[DATA_W-1:0];
`else
        acc_t s = w >>> 2;
        return s[DATA_W-1:0];
`endif
    endfunction

    logic             xfer, last_col, last_row, pair_col, pool_row, win_done, lb_we;
    logic [DIM_W-1:0] cols_even, rows_even;
    acc_t             in_ext, pair, lb_rd, win;

    assign cols_even = {cols_q[DIM_W-1:1], 1'b0};
    assign rows_even = {rows_q[DIM_W-1:1], 1'b0};
    assign last_col  = (col_q == cols_q - DIM_W'(1));
    assign last_row  = (row_q == rows_q - DIM_W'(1));
    // Odd column inside the pooled width: this sample closes a horizontal pair.
    assign pair_col  = col_q[0] && (col_q < cols_even);
    assign pool_row  = (row_q < rows_even);
    // Odd rows are always inside the pooled height (a trailing row is even).
    assign win_done  = (state_q == ODD_ROW) && pair_col;

    assign in_ext = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign pair   = combine(hold_q, in_ext);
    assign win    = combine(pair, lb_rd);
    assign xfer   = in_valid && in_ready;
    assign lb_we  = xfer && (state_q == EVEN_ROW) && pair_col && pool_row;

    pool_line_buf u_line_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (lb_we),
        .addr_i    (col_q[LB_AW:1]),
        .wr_data_i (pair),
        .rd_data_o (lb_rd)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = EVEN_ROW;
            end
            EVEN_ROW, ODD_ROW: begin
                if (xfer && last_col) begin
                    if (last_row)                state_d = DRAIN;
                    else if (state_q == EVEN_ROW) state_d = ODD_ROW;
                    else                         state_d = EVEN_ROW;
                end
            end
            DRAIN: begin
                if (!out_valid_q || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Input is stalled only when the sample would produce a
    // result while the output register is still occupied.
    always_comb begin
        busy     = (state_q != IDLE);
        in_ready = busy && (state_q != DRAIN) &&
                   !(out_valid_q && !out_ready && win_done);
    end

    // Counters, horizontal hold register and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cols_q      <= '0;
            rows_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            finish_q    <= 1'b0;
        end else begin
            // Fires on the edge where DRAIN sees the output register empty
            // (or emptying), so busy falls in the same cycle finish is high.
            finish_q <= (state_q == DRAIN) && (!out_valid_q || out_ready);

            if ((state_q == IDLE) && start) begin
                cols_q <= cols;
                rows_q <= rows;
                col_q  <= '0;
                row_q  <= '0;
                hold_q <= '0;
            end else if (xfer) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + DIM_W'(1);
                end else begin
                    col_q <= col_q + DIM_W'(1);
                end
                if (!col_q[0]) hold_q <= in_ext;
            end

            if (xfer && win_done) begin
                out_valid_q <= 1'b1;
                out_data_q  <= finalize(win);
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_pool_2x2_stream.sv
module tb_pool_2x2_stream;

`ifdef POOL_MAX_EN
    localparam bit MAX_MODE = 1'b1;
`else
    localparam bit MAX_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, out_valid, out_ready, busy, finish;
    logic [5:0]  cols, rows;
    logic [15:0] in_data, out_data;

    int n_cmp = 0;
    int n_bad = 0;
    int stim[$];
    int exp_q[$];

    typedef struct {
        int cols;
        int rows;
        int base;
        int step;
        int n;
        int ea[2];
        int em[2];
    } tv_t;
    tv_t tv[6];

    always #5 clk = ~clk;

    pool_2x2_stream dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cols      (cols),
        .rows      (rows),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .finish    (finish)
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void set_tv(input int i, input int c, input int r, input int b,
                                   input int s, input int n, input int a0, input int a1,
                                   input int m0, input int m1);
        tv[i].cols = c; tv[i].rows = r; tv[i].base = b; tv[i].step = s; tv[i].n = n;
        tv[i].ea[0] = a0; tv[i].ea[1] = a1; tv[i].em[0] = m0; tv[i].em[1] = m1;
    endfunction

    // Does raster sample idx complete a pooled 2x2 window?
    function automatic bit completes(input int idx, input int c, input int r);
        int rr = idx / c;
        int cc = idx % c;
        return (rr % 2 == 1) && (cc % 2 == 1) && (rr < (r / 2) * 2) && (cc < (c / 2) * 2);
    endfunction

    // Reference: pool the map held in stim window by window.
    function automatic void model(input int c, input int r);
        exp_q.delete();
        for (int pr = 0; pr < r / 2; pr++) begin
            for (int pc = 0; pc < c / 2; pc++) begin
                int w[4];
                int m;
                w[0] = stim[(2 * pr) * c + 2 * pc];
                w[1] = stim[(2 * pr) * c + 2 * pc + 1];
                w[2] = stim[(2 * pr + 1) * c + 2 * pc];
                w[3] = stim[(2 * pr + 1) * c + 2 * pc + 1];
                if (MAX_MODE) begin
                    m = w[0];
                    for (int k = 1; k < 4; k++) if (w[k] > m) m = w[k];
                    exp_q.push_back(m);
                end else begin
                    exp_q.push_back((w[0] + w[1] + w[2] + w[3]) >>> 2);
                end
            end
        end
    endfunction

    // Run one map from stim, comparing against exp_q. Called at a negedge.
    task automatic run_map(input int c, input int r, input bit rnd,
                           input int glitch_at, input string tag);
        int   n = c * r;
        int   sent = 0;
        int   cyc = 0;
        int   last_hs = -10;
        int   budget = n * 10 + 200;
        bit   fin_seen = 0;
        bit   glitched = 0;
        bit   exp_valid_next = 0;
        bit   stall_prev = 0;
        logic [15:0] prev_data = '0;

        @(negedge clk);
        start = 1'b1; cols = 6'(c); rows = 6'(r); in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_ready_rise"}, in_ready, 1);

        while (!fin_seen && cyc < budget) begin
            start = 1'b0; cols = 6'(c); rows = 6'(r);
            if (glitch_at >= 0 && sent == glitch_at && !glitched) begin
                start = 1'b1; cols = 6'd4; rows = 6'd2; glitched = 1;
            end
            in_valid  = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_data   = (sent < n) ? 16'(stim[sent]) : 16'h0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (exp_valid_next) check({tag, "_latency"}, out_valid, 1);
            if (stall_prev) begin
                check({tag, "_stall_valid"}, out_valid, 1);
                check({tag, "_stall_data"}, out_data, prev_data);
            end
            if (finish) begin
                fin_seen = 1;
                check({tag, "_finish_busy"}, busy, 0);
                check({tag, "_outputs_left"}, exp_q.size(), 0);
                check({tag, "_samples_sent"}, sent, n);
                if (c % 2 == 0 && r % 2 == 0) check({tag, "_finish_timing"}, cyc, last_hs + 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_output"}, $signed(out_data), 64'sh7fff_ffff);
                end else begin
                    check({tag, "_out"}, $signed(out_data), exp_q.pop_front());
                end
                last_hs = cyc;
            end
            exp_valid_next = in_valid && in_ready && completes(sent, c, r);
            if (in_valid && in_ready) sent++;
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            @(negedge clk);
            cyc++;
        end
        if (!fin_seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no finish after %0d cycles (sent %0d of %0d)",
                     tag, cyc, sent, n);
        end
        in_valid = 1'b0; start = 1'b0;
        #1;
        check({tag, "_finish_pulse"}, finish, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        logic [15:0] r16;
        int fed;
        int fins;
        int cyc;

        set_tv(0, 4, 2,      1,  1, 2,      3,  5,      6,  8);
        set_tv(1, 2, 2,     -1, -1, 1,     -3,  0,     -1,  0);
        set_tv(2, 2, 2,  32767,  0, 1,  32767,  0,  32767,  0);
        set_tv(3, 5, 3,      1,  1, 2,      4,  6,      7,  9);
        set_tv(4, 3, 2, -32768,  0, 1, -32768,  0, -32768,  0);
        set_tv(5, 2, 3,     10,  3, 1,     14,  0,     19,  0);

        reset = 1'b1; start = 1'b0; cols = '0; rows = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_finish", finish, 0);

        reset = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
        @(negedge clk);
        #1;
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        in_valid = 1'b0;

        // Table vectors.
        for (int i = 0; i < 6; i++) begin
            stim.delete();
            exp_q.delete();
            for (int k = 0; k < tv[i].cols * tv[i].rows; k++) stim.push_back(tv[i].base + k * tv[i].step);
            for (int k = 0; k < tv[i].n; k++) exp_q.push_back(MAX_MODE ? tv[i].em[k] : tv[i].ea[k]);
            run_map(tv[i].cols, tv[i].rows, i[0], -1, $sformatf("vec%0d", i));
        end

        // Random 28x28 with a start pulse mid-map that must be ignored.
        stim.delete();
        for (int k = 0; k < 28 * 28; k++) begin
            r16 = 16'($urandom);
            stim.push_back(int'($signed(r16)));
        end
        model(28, 28);
        run_map(28, 28, 1'b1, 300, "rand28");

        // Random odd-sized map.
        stim.delete();
        for (int k = 0; k < 27 * 7; k++) begin
            r16 = 16'($urandom);
            stim.push_back(int'($signed(r16)));
        end
        model(27, 7);
        run_map(27, 7, 1'b1, -1, "rand27x7");

        // Abort a 28x28 map with reset after 10 samples.
        @(negedge clk);
        start = 1'b1; cols = 6'd28; rows = 6'd28; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fed = 0; fins = 0; cyc = 0;
        while (fed < 10 && cyc < 100) begin
            in_valid = 1'b1; in_data = 16'(fed * 7);
            #1;
            if (finish) fins++;
            if (in_ready) fed++;
            @(negedge clk);
            cyc++;
        end
        check("abort_fed", fed, 10);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (finish) fins++;
        end
        check("abort_no_finish", fins, 0);

        stim.delete();
        exp_q.delete();
        for (int k = 0; k < 8; k++) stim.push_back(k + 1);
        model(4, 2);
        run_map(4, 2, 1'b0, -1, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
